// File: rtl/spi_flash_target.sv
// SPI NOR flash target emulator: decodes READ/PP/RDSR/RDID/WREN/WRDI from an asynchronous
// mode-0 SPI master and drives byte-wide strobes to a backing memory in the clk domain.
module spi_flash_target #(
  parameter logic [23:0] JEDEC_ID    = 24'hEF4017,
  parameter int unsigned PROG_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SPI_CLK,
  input  logic        SPI_CS_n,
  input  logic        SPI_MOSI,
  output logic        SPI_MISO,
  output logic        miso_oe,
  output logic [23:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata
);

  localparam int unsigned CntW = $clog2(PROG_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddr, StRead, StStatus, StId, StProg, StIgnore
  } state_t;

  state_t          state;
  logic [1:0]      sck_sync, cs_sync, mosi_sync;
  logic            sck_prev, cs_prev, armed;
  logic [1:0]      settle;
  logic [4:0]      bit_cnt;
  logic [7:0]      shift_in, tx_sh, rd_buf;
  logic [1:0]      id_idx;
  logic            wel, wip, is_prog, first, cap;
  logic [CntW-1:0] wip_cnt;
  logic            sck_rise, sck_fall, cs_rise, cs_fall, mosi;
  logic [7:0]      opcode, id_byte, next_byte;

  always_comb begin
    mosi     = mosi_sync[1];
    sck_rise = sck_sync[1] & ~sck_prev;
    sck_fall = ~sck_sync[1] & sck_prev;
    // Edges on CS are ignored until a genuine high level has been seen after reset.
    cs_rise  = armed & cs_sync[1] & ~cs_prev;
    cs_fall  = armed & ~cs_sync[1] & cs_prev;
    opcode   = {shift_in[6:0], mosi};
    case (id_idx)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      2'd2:    id_byte = JEDEC_ID[7:0];
      default: id_byte = 8'h00;
    endcase
    case (state)
      StRead:   next_byte = rd_buf;
      StStatus: next_byte = {6'b0, wel, wip};
      StId:     next_byte = id_byte;
      default:  next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      sck_sync  <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sck_prev  <= 1'b0;
      cs_prev   <= 1'b1;
      armed     <= 1'b0;
      settle    <= 2'd0;
      bit_cnt   <= 5'd0;
      shift_in  <= 8'h00;
      tx_sh     <= 8'h00;
      rd_buf    <= 8'h00;
      id_idx    <= 2'd0;
      wel       <= 1'b0;
      wip       <= 1'b0;
      wip_cnt   <= '0;
      is_prog   <= 1'b0;
      first     <= 1'b0;
      cap       <= 1'b0;
      mem_addr  <= 24'h0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= 8'h00;
      SPI_MISO  <= 1'b0;
      miso_oe   <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], SPI_CLK};
      cs_sync   <= {cs_sync[0], SPI_CS_n};
      mosi_sync <= {mosi_sync[0], SPI_MOSI};
      sck_prev  <= sck_sync[1];
      cs_prev   <= cs_sync[1];
      if (settle != 2'd2) settle <= settle + 2'd1;
      else if (cs_sync[1]) armed <= 1'b1;

      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      cap    <= mem_rd;
      // Page program wraps inside the 256-byte page.
      if (mem_wr) mem_addr[7:0] <= mem_addr[7:0] + 8'd1;

      if (wip) begin
        if (wip_cnt == CntW'(1)) wip <= 1'b0;
        wip_cnt <= wip_cnt - CntW'(1);
      end

      // mem_rdata is valid the cycle after mem_rd; the first byte goes straight to MISO.
      if (cap && state == StRead) begin
        rd_buf <= mem_rdata;
        if (first) begin
          tx_sh    <= mem_rdata;
          SPI_MISO <= mem_rdata[7];
          first    <= 1'b0;
        end
      end

      if (cs_rise) begin
        if (state == StProg) begin
          wel     <= 1'b0;
          wip     <= 1'b1;
          wip_cnt <= CntW'(PROG_CYCLES);
        end
        state    <= StIdle;
        bit_cnt  <= 5'd0;
        SPI_MISO <= 1'b0;
        miso_oe  <= 1'b0;
      end else begin
        case (state)
          StIdle: begin
            if (cs_fall) begin
              state   <= StCmd;
              bit_cnt <= 5'd0;
            end
          end
          StCmd: begin
            if (sck_rise) begin
              shift_in <= opcode;
              bit_cnt  <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd7) begin
                bit_cnt <= 5'd0;
                if (wip && opcode != 8'h05) begin
                  state <= StIgnore;
                end else begin
                  case (opcode)
                    8'h03: begin state <= StAddr; is_prog <= 1'b0; end
                    8'h02: begin
                      if (wel) begin state <= StAddr; is_prog <= 1'b1; end
                      else state <= StIgnore;
                    end
                    8'h05: begin state <= StStatus; bit_cnt <= 5'd8; miso_oe <= 1'b1; end
                    8'h9F: begin
                      state   <= StId;
                      id_idx  <= 2'd0;
                      bit_cnt <= 5'd8;
                      miso_oe <= 1'b1;
                    end
                    8'h06:   begin wel <= 1'b1; state <= StIgnore; end
                    8'h04:   begin wel <= 1'b0; state <= StIgnore; end
                    default: state <= StIgnore;
                  endcase
                end
              end
            end
          end
          StAddr: begin
            if (sck_rise) begin
              mem_addr <= {mem_addr[22:0], mosi};
              bit_cnt  <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd23) begin
                bit_cnt <= 5'd0;
                if (is_prog) begin
                  state <= StProg;
                end else begin
                  state   <= StRead;
                  mem_rd  <= 1'b1;
                  first   <= 1'b1;
                  miso_oe <= 1'b1;
                end
              end
            end
          end
          StRead, StStatus, StId: begin
            // bit_cnt counts master samples; 8 means the next falling edge starts a byte.
            if (sck_rise) begin
              bit_cnt <= bit_cnt + 5'd1;
              if (state == StRead && bit_cnt == 5'd7) begin
                mem_addr <= mem_addr + 24'd1;
                mem_rd   <= 1'b1;
              end
            end else if (sck_fall) begin
              if (bit_cnt == 5'd8) begin
                tx_sh    <= next_byte;
                SPI_MISO <= next_byte[7];
                bit_cnt  <= 5'd0;
                if (state == StId && id_idx != 2'd3) id_idx <= id_idx + 2'd1;
              end else if (bit_cnt != 5'd0) begin
                SPI_MISO <= tx_sh[6];
                tx_sh    <= {tx_sh[6:0], 1'b0};
              end
            end
          end
          StProg: begin
            if (sck_rise) begin
              shift_in <= {shift_in[6:0], mosi};
              bit_cnt  <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd7) begin
                bit_cnt   <= 5'd0;
                mem_wr    <= 1'b1;
                mem_wdata <= {shift_in[6:0], mosi};
              end
            end
          end
          StIgnore: ;
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: doc/spi_flash_target.md
SPI_FLASH_TARGET -- requirements
Module: spi_flash_target

Interface
REQ-001 Parameter JEDEC_ID, 24'hEF4017, 3-byte value returned by command 0x9F, MSB first.
REQ-002 Parameter PROG_CYCLES, 64, number of clk cycles WIP stays set after a page program.
REQ-003 clk  in  1  system clock; single clock domain.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 SPI_CLK  in  1  asynchronous SPI clock from the flash-reading master, mode 0.
REQ-006 SPI_CS_n  in  1  asynchronous chip select, active low.
REQ-007 SPI_MOSI  in  1  asynchronous serial data in.
REQ-008 SPI_MISO  out  1  serial data out, MSB first.
REQ-009 miso_oe  out  1  1 = drive SPI_MISO, 0 = tristate at top level.
REQ-010 mem_addr  out  24  byte address to backing memory.
REQ-011 mem_rd  out  1  one-clk read strobe.
REQ-012 mem_rdata  in  8  read data, valid exactly one clk after mem_rd.
REQ-013 mem_wr  out  1  one-clk write strobe.
REQ-014 mem_wdata  out  8  write data, valid while mem_wr=1.

Function
REQ-015 SPI_CLK, SPI_CS_n and SPI_MOSI SHALL each pass through a 2-flop synchronizer; edges are detected on the synchronized SPI_CLK.
REQ-016 Supported SPI_CLK: high and low phases each >=5 clk; faster clocks are out of scope.
REQ-017 MOSI SHALL be sampled on synchronized SPI_CLK rising edges; MISO SHALL change only on synchronized falling edges, except the first data bit (REQ-023).
REQ-018 States: IDLE, CMD, ADDR, READ, STATUS, ID, PROG, IGNORE.
REQ-019 IDLE->CMD on synchronized SPI_CS_n falling; bit counter cleared.
REQ-020 CMD, after 8 bits: 0x03->ADDR(read); 0x02 with WEL=1->ADDR(program); 0x05->STATUS; 0x9F->ID; 0x06 sets WEL->IGNORE; 0x04 clears WEL->IGNORE; any other opcode, or 0x02 with WEL=0->IGNORE.
REQ-021 While WIP=1 every opcode except 0x05 SHALL go to IGNORE without side effect.
REQ-022 ADDR shifts 24 bits MSB first into the address register.
REQ-023 Read: on the 24th address bit, issue mem_rd for that address; load mem_rdata into the MISO shifter the next clk; present bit 7 on SPI_MISO immediately.
REQ-024 Read: after each 8th data bit is shifted out, increment the address (24-bit wrap FFFFFF->000000), issue mem_rd, reload; streaming is unbounded while CS_n low.
REQ-025 STATUS outputs {6'b0, WEL, WIP} repeatedly, refreshed at each byte boundary.
REQ-026 ID outputs JEDEC_ID[23:16], [15:8], [7:0], then 0x00 for every further byte.
REQ-027 PROG: each completed received byte yields one mem_wr pulse at the current address; only address[7:0] then increments (wrap within the 256-byte page).
REQ-028 PROG: on SPI_CS_n rising, clear WEL and set WIP; a down-counter clears WIP after PROG_CYCLES clk.
REQ-029 miso_oe=1 only in READ, STATUS, ID and only while SPI_CS_n is low; otherwise 0.
REQ-030 Synchronized SPI_CS_n rising in any state SHALL return to IDLE within 1 clk; any partial byte is discarded (no mem_wr); miso_oe drops.
REQ-031 mem_rd and mem_wr SHALL never both be 1 and SHALL each be exactly 1 clk wide.
REQ-032 Bits after the opcode in IGNORE are discarded until CS_n rises.

Reset
REQ-033 On rst: state=IDLE, WEL=0, WIP=0, WIP counter=0, mem_addr=0, mem_rd=0, mem_wr=0, mem_wdata=0, SPI_MISO=0, miso_oe=0, synchronizers=idle levels (CS_n=1, SCK=0).
REQ-034 rst mid-transaction aborts with no further mem strobe; the block waits for a fresh CS_n falling edge before decoding.

Verification
REQ-035 Read 0x03 addr 0x012345, mem returns 0xA5,0x3C -> mem_rd at 0x012345 then 0x012346; MISO bytes 0xA5,0x3C.
REQ-036 Read at 0xFFFFFF, 2 bytes -> second mem_rd at 0x000000.
REQ-037 0x02 without WREN, addr 0x000100, data 0x11 -> no mem_wr; then 0x05 -> 0x00.
REQ-038 0x06; 0x02 addr 0x0001FF, data 0x11,0x22; CS_n high -> mem_wr 0x11@0x0001FF, 0x22@0x000100; 0x05 immediately -> 0x01; after PROG_CYCLES -> 0x00.
REQ-039 0x9F, 4 bytes -> 0xEF,0x40,0x17,0x00.
REQ-040 CS_n raised after 3 data bits in PROG, and rst asserted mid-read -> no mem_wr, no extra mem_rd, miso_oe=0, next transaction decodes normally.
